cam_reg_init: RTL and testbench

Camera register initialisation sequencer. Walks an external table of {register, value} entries and issues one SCCB write per entry to the camera's two-wire bus driver. Waits for each transfer to complete, retries on NACK or timeout, and supports inline delay entries, such as the settle time after a soft reset. Sits directly upstream of the bus driver, between the camera top level and the driver's write-request, address and data inputs.

---
 rtl/cam_reg_init.sv | 195 +++++++++++++++++++
 tb/tb_cam_reg_init.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_reg_init.sv
// Camera register initialisation sequencer: walks a {reg, val} table and issues
// one SCCB write per entry, with retry on NACK/timeout and inline delay entries.
module cam_reg_init #(
    parameter int DELAY_UNIT = 1000,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        iic_wr_en,
    output logic [7:0]  iic_addr,
    output logic [7:0]  iic_wr_data,
    input  logic        iic_done,
    input  logic        iic_ack,
    output logic        busy,
    output logic        init_done,
    output logic        init_err,
    output logic [7:0]  err_index
);

    localparam int UW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
    localparam int RW = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [UW-1:0] UNIT_LAST = UW'(DELAY_UNIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DELAY, S_DONE, S_ERR
    } state_t;

    state_t        state_q;
    logic [7:0]    idx_q;
    logic [7:0]    addr_q, data_q;
    logic          wr_en_q, busy_q, done_q, err_q;
    logic [7:0]    err_idx_q;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] tmo_q;
    logic [GW-1:0] gap_q;
    logic [UW-1:0] unit_q;
    logic [7:0]    step_q;
    logic          pend_retry_q;   // GAP target: 1 = reissue same write, 0 = next entry
    logic          done_prev_q;

    logic done_rise_d;
    logic last_entry_d;

    assign done_rise_d  = iic_done & ~done_prev_q;
    assign last_entry_d = (idx_q == 8'hFF);

    // Sequencer FSM; every output is a register updated with the state edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 8'd0;
            addr_q       <= 8'd0;
            data_q       <= 8'd0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_idx_q    <= 8'd0;
            retry_q      <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            unit_q       <= '0;
            step_q       <= 8'd0;
            pend_retry_q <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            done_prev_q <= iic_done;
            wr_en_q     <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        idx_q     <= 8'd0;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        err_idx_q <= 8'd0;
                        busy_q    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (rom_data == 16'hFFFF) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (rom_data[15:8] == 8'hFF) begin
                        if (rom_data[7:0] == 8'd0) begin
                            // zero-length delay: skip straight to the next entry
                            if (last_entry_d) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                idx_q <= idx_q + 8'd1;
                            end
                        end else begin
                            step_q  <= rom_data[7:0];
                            unit_q  <= '0;
                            state_q <= S_DELAY;
                        end
                    end else begin
                        addr_q  <= rom_data[15:8];
                        data_q  <= rom_data[7:0];
                        retry_q <= '0;
                        wr_en_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_rise_d && iic_ack) begin
                        pend_retry_q <= 1'b0;
                        gap_q        <= '0;
                        state_q      <= S_GAP;
                    end else if (done_rise_d || (tmo_q == TMO_LAST)) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q      <= retry_q + 1'b1;
                            pend_retry_q <= 1'b1;
                            gap_q        <= '0;
                            state_q      <= S_GAP;
                        end else begin
                            state_q   <= S_ERR;
                            err_q     <= 1'b1;
                            err_idx_q <= idx_q;
                            busy_q    <= 1'b0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (pend_retry_q) begin
                            wr_en_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end else if (last_entry_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 8'd1;
                            state_q <= S_FETCH;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_DELAY: begin
                    // unit counter is the inner loop, step the outer one
                    if (unit_q == UNIT_LAST) begin
                        unit_q <= '0;
                        if (step_q == 8'd1) begin
                            if (last_entry_d) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                idx_q   <= idx_q + 8'd1;
                                state_q <= S_FETCH;
                            end
                        end else begin
                            step_q <= step_q - 8'd1;
                        end
                    end else begin
                        unit_q <= unit_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr    = idx_q;
    assign iic_wr_en   = wr_en_q;
    assign iic_addr    = addr_q;
    assign iic_wr_data = data_q;
    assign busy        = busy_q;
    assign init_done   = done_q;
    assign init_err    = err_q;
    assign err_index   = err_idx_q;

endmodule

// File: tb/tb_cam_reg_init.sv
// Bench for cam_reg_init: table ROM, SCCB driver model and write scoreboard.
module tb_cam_reg_init;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        iic_wr_en;
    logic [7:0]  iic_addr, iic_wr_data;
    logic        iic_done, iic_ack;
    logic        busy, init_done, init_err;
    logic [7:0]  err_index;

    cam_reg_init #(
        .DELAY_UNIT(10), .GAP_CYCLES(4), .MAX_RETRY(3), .TIMEOUT(50)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .iic_wr_en(iic_wr_en), .iic_addr(iic_addr), .iic_wr_data(iic_wr_data),
        .iic_done(iic_done), .iic_ack(iic_ack),
        .busy(busy), .init_done(init_done), .init_err(init_err),
        .err_index(err_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [256];
    assign rom_data = rom[rom_addr];

    logic [15:0] exp_q [$];
    int          pulse_cyc [$];
    int          fetch_cyc [256];
    logic [7:0]  last_addr = 8'd0;
    logic [15:0] sb_e;
    int          n_chk = 0, n_err = 0;
    int          nack_left = 0;
    bit          silent = 1'b0;
    int          dcnt = 0;
    logic        nxt_ack = 1'b1;
    int          st_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver model + scoreboard: every write pulse is popped against the queue.
    initial begin
        iic_done = 1'b0;
        iic_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (rom_addr != last_addr) begin
                fetch_cyc[rom_addr] = cyc;
                last_addr = rom_addr;
            end
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    iic_done = 1'b1;
                    iic_ack  = nxt_ack;
                end
            end
            if (iic_wr_en) begin
                pulse_cyc.push_back(cyc);
                check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    check("sb_addr_data", {16'd0, iic_addr, iic_wr_data}, {16'd0, sb_e});
                end
                iic_done = 1'b0;
                iic_ack  = 1'b0;
                if (nack_left > 0) begin
                    nxt_ack = 1'b0;
                    nack_left--;
                end else begin
                    nxt_ack = 1'b1;
                end
                dcnt = silent ? 0 : LAT;
            end
        end
    end

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic go();
        @(negedge clk);
        start  = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_end(input int maxc);
        for (int i = 0; i < maxc && !(init_done || init_err); i++) @(negedge clk);
        check("end_reached", 32'(init_done | init_err), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill(16'hFFFF);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_err", 32'(init_err), 32'd0);
        check("rst_wr_en", 32'(iic_wr_en), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic two-write sequence
        fill(16'hFFFF); rom[0] = 16'h1280; rom[1] = 16'h1101;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        pulse_cyc.delete();
        go();
        wait_end(400);
        check("t1_done", 32'(init_done), 32'd1);
        check("t1_err", 32'(init_err), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_pulses", 32'(pulse_cyc.size()), 32'd2);
        check("t1_first_lat", 32'(pulse_cyc[0] - st_cyc), 32'd2);
        check("t1_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(LAT + 4 + 2));
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // inline delay entry
        fill(16'hFFFF); rom[0] = 16'h1280; rom[1] = 16'hFF03; rom[2] = 16'h1101;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        pulse_cyc.delete();
        go();
        wait_end(500);
        check("t2_done", 32'(init_done), 32'd1);
        check("t2_delay", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd31);
        check("t2_pulses", 32'(pulse_cyc.size()), 32'd2);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // two NACKs then success
        fill(16'hFFFF); rom[0] = 16'h1280; rom[1] = 16'h1101;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        nack_left = 2;
        pulse_cyc.delete();
        go();
        wait_end(800);
        check("t3_done", 32'(init_done), 32'd1);
        check("t3_err", 32'(init_err), 32'd0);
        check("t3_pulses", 32'(pulse_cyc.size()), 32'd4);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // four NACKs exhaust the retries
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1280);
        nack_left = 4;
        pulse_cyc.delete();
        go();
        wait_end(800);
        repeat (100) @(negedge clk);
        check("t4_err", 32'(init_err), 32'd1);
        check("t4_done", 32'(init_done), 32'd0);
        check("t4_err_index", 32'(err_index), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_pulses", 32'(pulse_cyc.size()), 32'd4);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // silent driver: timeout retries
        silent = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1280);
        pulse_cyc.delete();
        go();
        wait_end(600);
        check("t5_err", 32'(init_err), 32'd1);
        check("t5_err_index", 32'(err_index), 32'd0);
        check("t5_pulses", 32'(pulse_cyc.size()), 32'd4);
        for (int i = 0; i < 3; i++)
            check("t5_retry_period", 32'(pulse_cyc[i+1] - pulse_cyc[i]), 32'd55);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        silent = 1'b0;

        // reset in the middle of WAIT, then restart from index 0
        exp_q.push_back(16'h1280);
        pulse_cyc.delete();
        go();
        for (int i = 0; i < 20 && pulse_cyc.size() == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(init_done), 32'd0);
        check("t6_err", 32'(init_err), 32'd0);
        check("t6_wr_en", 32'(iic_wr_en), 32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t6_idle", 32'(busy), 32'd0);
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        go();
        wait_end(400);
        check("t6_redone", 32'(init_done), 32'd1);
        check("t6_pulses", 32'(pulse_cyc.size()), 32'd3);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        // start held during a run must not restart it
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        pulse_cyc.delete();
        @(negedge clk);
        start = 1'b1;
        repeat (60) @(negedge clk);
        start = 1'b0;
        wait_end(400);
        check("t7_done", 32'(init_done), 32'd1);
        check("t7_pulses", 32'(pulse_cyc.size()), 32'd2);
        // start in DONE runs a second full sequence
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        go();
        check("t7_done_cleared", 32'(init_done), 32'd0);
        check("t7_busy_again", 32'(busy), 32'd1);
        wait_end(400);
        check("t7_done2", 32'(init_done), 32'd1);
        check("t7_pulses2", 32'(pulse_cyc.size()), 32'd4);
        check("t7_sb_empty", 32'(exp_q.size()), 32'd0);

        // index limit: 256 zero-delay entries, no end marker
        fill(16'hFF00);
        pulse_cyc.delete();
        go();
        wait_end(600);
        check("t8_done", 32'(init_done), 32'd1);
        check("t8_last_index", 32'(rom_addr), 32'd255);
        check("t8_pulses", 32'(pulse_cyc.size()), 32'd0);
        check("t8_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
